// File: rtl/fwpayload_wb_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : fwpayload_wb_mailbox
//  Purpose  : Wishbone classic slave that exposes two word-wide FIFO
//             mailboxes between host firmware and the payload core:
//             host-to-core (TX) and core-to-host (RX). It also provides a
//             status register, a control register and a level interrupt.
//             The core side uses valid/ready streams.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    wb_clk_i    in   1   clock for the whole block
//    wb_rst_ni   in   1   asynchronous active-low reset
//    wbs_*_i     in       wishbone classic slave inputs (stb, cyc, we, sel,
//                         adr, dat)
//    wbs_ack_o   out  1   wishbone acknowledge, one cycle per access
//    wbs_dat_o   out  32  wishbone read data, zero whenever ack is low
//    tx_data_o   out  32  head of TX FIFO, registered, holds when empty
//    tx_valid_o  out  1   TX FIFO not empty
//    tx_ready_i  in   1   core accepts tx_data_o
//    rx_data_i   in   32  word offered by the core
//    rx_valid_i  in   1   core offers rx_data_i
//    rx_ready_o  out  1   RX FIFO not full
//    irq_o       out  1   level interrupt: rx_irq_en & RX not empty
//  Register map (offset from BASE_ADDR)
//    0x0 TX_DATA  W: push (sel must be 4'hF)        R: 0
//    0x4 RX_DATA  R: pop head (0 + rx_unf if empty)  W: ignored
//    0x8 STATUS   R: counts/flags/sticky bits        W: clears sticky bits
//    0xC CTRL     [0] rx_irq_en, [1] fifo_clr (self-clearing, reads 0)
// ============================================================================
module fwpayload_wb_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 4,
    parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int         PTR_W      = $clog2(DEPTH);
    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_RX     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       hit;
    logic       access;
    logic       wr_access;
    logic       rd_access;
    logic [1:0] offset;
    logic       unused_adr_bits;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // An access is performed only on the edge that raises ack; a held
    // strobe therefore gets serviced every other cycle.
    assign access    = hit & ~wbs_ack_o;
    assign wr_access = access & wbs_we_i;
    assign rd_access = access & ~wbs_we_i;
    assign offset    = wbs_adr_i[3:2];
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // ------------------------------------------------------------------
    // Control / sticky state
    // ------------------------------------------------------------------
    logic rx_irq_en;
    logic tx_ovf;
    logic rx_unf;
    logic fifo_clr;

    assign fifo_clr = wr_access & (offset == OFF_CTRL) & wbs_dat_i[1];

    // ------------------------------------------------------------------
    // TX FIFO (host -> core)
    // ------------------------------------------------------------------
    logic [31:0]      tx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr;
    logic [PTR_W-1:0] tx_rd_ptr;
    logic [PTR_W-1:0] tx_rd_next;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] tx_count_next;
    logic [CNT_W-1:0] tx_remain;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push_req;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_ovf_set;

    assign tx_full     = (tx_count == CNT_W'(DEPTH));
    assign tx_empty    = (tx_count == '0);
    assign tx_valid_o  = ~tx_empty;
    assign tx_push_req = wr_access & (offset == OFF_TX) & (wbs_sel_i == 4'hF);
    // A clear discards any core handshake on the same edge.
    assign tx_pop      = tx_valid_o & tx_ready_i & ~fifo_clr;
    // A full FIFO still accepts a push when the core pops on the same edge.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_ovf_set  = tx_push_req & ~tx_push;
    assign tx_rd_next  = tx_pop ? tx_rd_ptr + PTR_W'(1) : tx_rd_ptr;
    assign tx_remain   = tx_pop ? tx_count - CNT_W'(1) : tx_count;

    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + CNT_W'(1);
            2'b01:   tx_count_next = tx_count - CNT_W'(1);
            default: tx_count_next = tx_count;
        endcase
        if (fifo_clr) begin
            tx_count_next = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            tx_data_o <= '0;
        end else begin
            tx_count <= tx_count_next;
            if (fifo_clr) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
            end else begin
                if (tx_push) begin
                    tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
                end
                tx_rd_ptr <= tx_rd_next;
                // Head register: when the only surviving entry is the one
                // being written now, bypass the memory; otherwise load the
                // entry at the new read pointer. An empty FIFO holds.
                if (tx_remain == '0) begin
                    if (tx_push) begin
                        tx_data_o <= wbs_dat_i;
                    end
                end else begin
                    tx_data_o <= tx_mem[tx_rd_next];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (core -> host)
    // ------------------------------------------------------------------
    logic [31:0]      rx_mem [DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr;
    logic [PTR_W-1:0] rx_rd_ptr;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] rx_count_next;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_rd_req;
    logic             rx_pop;
    logic             rx_unf_set;
    logic [31:0]      rx_head;

    assign rx_full    = (rx_count == CNT_W'(DEPTH));
    assign rx_empty   = (rx_count == '0);
    assign rx_ready_o = ~rx_full;
    assign rx_push    = rx_valid_i & rx_ready_o & ~fifo_clr;
    assign rx_rd_req  = rd_access & (offset == OFF_RX);
    // Emptiness is judged before this edge's core push, so a read racing
    // the first push sees an empty FIFO and the pushed word is kept.
    assign rx_pop     = rx_rd_req & ~rx_empty;
    assign rx_unf_set = rx_rd_req & rx_empty;
    assign rx_head    = rx_mem[rx_rd_ptr];

    always_comb begin
        rx_count_next = rx_count;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count + CNT_W'(1);
            2'b01:   rx_count_next = rx_count - CNT_W'(1);
            default: rx_count_next = rx_count;
        endcase
        if (fifo_clr) begin
            rx_count_next = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            rx_count <= rx_count_next;
            if (fifo_clr) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
            end else begin
                if (rx_push) begin
                    rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
                end
                if (rx_pop) begin
                    rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Status word and read mux
    // ------------------------------------------------------------------
    logic [31:0] status;
    logic [31:0] rdata;

    always_comb begin
        status                 = '0;
        status[CNT_W-1:0]      = tx_count;
        status[8+CNT_W-1:8]    = rx_count;
        status[16]             = tx_full;
        status[17]             = tx_empty;
        status[18]             = rx_full;
        status[19]             = rx_empty;
        status[24]             = tx_ovf;
        status[25]             = rx_unf;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_TX:     rdata = '0;
            OFF_RX:     rdata = rx_empty ? 32'h0 : rx_head;
            OFF_STATUS: rdata = status;
            OFF_CTRL:   rdata = {31'h0, rx_irq_en};
            default:    rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus response, control register, sticky bits, interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= rd_access ? rdata : 32'h0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_irq_en <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_unf    <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            if (wr_access && (offset == OFF_CTRL)) begin
                rx_irq_en <= wbs_dat_i[0];
            end
            if (wr_access && (offset == OFF_STATUS)) begin
                tx_ovf <= 1'b0;
                rx_unf <= 1'b0;
            end else begin
                if (tx_ovf_set) begin
                    tx_ovf <= 1'b1;
                end
                if (rx_unf_set) begin
                    rx_unf <= 1'b1;
                end
            end
            irq_o <= rx_irq_en & ~rx_empty;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwpayload_wb_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwpayload_wb_mailbox
//  Purpose  : Self-checking bench for fwpayload_wb_mailbox. Expected TX
//             words and expected RX read values are queued when stimulus
//             is driven and compared when the DUT delivers them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwpayload_wb_mailbox;

    localparam logic [31:0] A_TX     = 32'h3000_0000;
    localparam logic [31:0] A_RX     = 32'h3000_0004;
    localparam logic [31:0] A_STATUS = 32'h3000_0008;
    localparam logic [31:0] A_CTRL   = 32'h3000_000C;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] rd;
    logic [31:0] exp_w;
    logic        acks [4];

    fwpayload_wb_mailbox dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // TX scoreboard: every core handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            tests++;
            assert (tx_q.size() != 0) else begin
                fails++;
                $error("FAIL tx_unexpected: observed 0x%08h expected no word", tx_data);
            end
            if (tx_q.size() != 0) begin
                exp_w = tx_q.pop_front();
                check("tx_stream", tx_data, exp_w);
            end
        end
    end

    // One wishbone access, bounded wait for ack. Called at posedge+1.
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        tests++;
        assert (ack === 1'b1) else begin
            fails++;
            $error("FAIL wb_ack_timeout: observed ack %b expected 1 at addr 0x%08h", ack, a);
        end
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_access(1'b0, a, 32'h0, 4'hF, r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Drain TX with tx_ready high, bounded.
    task automatic drain_tx();
        int n;
        tx_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (tx_valid && n < 20);
        tx_ready = 1'b0;
        check("tx_drain_left", 32'(tx_q.size()), 32'd0);
        check("tx_valid_after_drain", {31'h0, tx_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; wdat = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        #12;
        // ---------------- reset values ----------------
        check("rst_ack",      {31'h0, ack},      32'h0);
        check("rst_dat",      rdat,              32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data",  tx_data,           32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_irq",      {31'h0, irq},      32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(A_STATUS, rd);
        check("status_idle", rd, 32'h000A_0000);

        // ---------------- TX fill, overflow, drain ----------------
        for (int i = 1; i <= 4; i++) begin
            wb_write(A_TX, 32'hA5A5_0000 + 32'(i));
            tx_q.push_back(32'hA5A5_0000 + 32'(i));
        end
        wb_read(A_STATUS, rd);
        check("status_tx_full", rd, 32'h0009_0004);
        check("tx_head", tx_data, 32'hA5A5_0001);
        wb_write(A_TX, 32'hDEAD_BEEF);
        wb_read(A_STATUS, rd);
        check("status_tx_ovf", rd, 32'h0109_0004);
        wb_write(A_STATUS, 32'h0);
        wb_read(A_STATUS, rd);
        check("status_ovf_cleared", rd, 32'h0009_0004);
        drain_tx();
        check("tx_data_hold", tx_data, 32'hA5A5_0004);

        // ---------------- RX path and interrupt ----------------
        wb_write(A_CTRL, 32'h1);
        rx_valid = 1'b1; rx_data = 32'h1111_1111;
        rx_q.push_back(32'h1111_1111);
        @(posedge clk); #1;
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        rx_data = 32'h2222_2222;
        rx_q.push_back(32'h2222_2222);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("irq_after_push", {31'h0, irq}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            exp_w = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
            wb_read(A_RX, rd);
            check("rx_read", rd, exp_w);
        end
        check("irq_low_after_pops", {31'h0, irq}, 32'h0);
        wb_read(A_STATUS, rd);
        check("status_rx_unf", rd, 32'h020A_0000);
        wb_write(A_STATUS, 32'hFFFF_FFFF);
        wb_read(A_STATUS, rd);
        check("status_unf_cleared", rd, 32'h000A_0000);

        // ---------------- handshake pattern, decode, sel ----------------
        idle(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acks[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check("ack_pattern", {28'h0, acks[0], acks[1], acks[2], acks[3]}, 32'hA);
        idle(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; wdat = 32'h1234_5678; sel = 4'hF;
        acks[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acks[0] = acks[0] | ack;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("no_ack_outside", {31'h0, acks[0]}, 32'h0);
        wb_access(1'b1, A_TX, 32'h0BAD_0BAD, 4'h3, rd);
        wb_read(A_STATUS, rd);
        check("partial_sel_ignored", rd, 32'h000A_0000);

        // ---------------- full TX with simultaneous pop and push ----------------
        for (int i = 1; i <= 4; i++) begin
            wb_write(A_TX, 32'hC0DE_0000 + 32'(i));
            tx_q.push_back(32'hC0DE_0000 + 32'(i));
        end
        idle(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TX; wdat = 32'h5555_0000; sel = 4'hF;
        tx_ready = 1'b1;
        tx_q.push_back(32'h5555_0000);
        @(posedge clk); #1;
        check("sim_push_ack", {31'h0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; tx_ready = 1'b0;
        wb_read(A_STATUS, rd);
        check("status_sim_push", rd, 32'h0009_0004);
        drain_tx();

        // ---------------- fifo clear ----------------
        for (int i = 0; i < 4; i++) begin
            wb_write(A_TX, 32'hF00D_0000 + 32'(i));
        end
        rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_data = $urandom;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
        wb_read(A_STATUS, rd);
        check("status_both_full", rd, 32'h0005_0404);
        wb_write(A_CTRL, 32'h2);
        tx_q.delete();
        check("clr_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("clr_rx_ready", {31'h0, rx_ready}, 32'h1);
        wb_read(A_STATUS, rd);
        check("status_after_clr", rd, 32'h000A_0000);
        wb_read(A_CTRL, rd);
        check("ctrl_reads_zero", rd, 32'h0);

        // ---------------- reset during an access ----------------
        idle(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TX; wdat = 32'h7777_7777; sel = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'h0, ack}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack_drop", {31'h0, ack},      32'h0);
        check("rst_tx_empty", {31'h0, tx_valid}, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        idle(2);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(A_STATUS, rd);
        check("status_after_rst", rd, 32'h000A_0000);
        check("tx_q_final", 32'(tx_q.size()), 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
